// File: rtl/wb_regfile_pkg.sv
// Shared widths and the writeback request payload for the writeback stage / register file.
package wb_regfile_pkg;

    localparam int unsigned REG_BUS      = 32;
    localparam int unsigned REG_ADDR_BUS = 5;
    localparam int unsigned REG_NUM      = 32;
    localparam int unsigned REG_NUM_LOG2 = 5;
    localparam int unsigned INSTRET_BUS  = 64;

    localparam logic [REG_ADDR_BUS-1:0] ZERO_REG_ADDR = '0;

    typedef struct packed {
        logic [REG_ADDR_BUS-1:0] addr;
        logic                    we;
        logic [REG_BUS-1:0]      data;
    } wb_req_t;

endpackage

// File: rtl/wb_regfile_if.sv
// Execute-to-writeback write request interface.
interface wb_regfile_if;
    import wb_regfile_pkg::*;

    wb_req_t req;

    modport master (output req);
    modport slave  (input  req);

endinterface

// File: rtl/wb_regfile_rd_port.sv
// One register-file read port: enable, x0 masking and optional writeback bypass.
// Bypass is selected by the REGFILE_BYPASS_EN macro.
module wb_regfile_rd_port
    import wb_regfile_pkg::*;
(
    input  logic                    rst,
    input  logic                    re,
    input  logic [REG_ADDR_BUS-1:0] raddr,
    input  logic [REG_BUS-1:0]      array_data,
    input  logic                    wb_we,
    input  logic [REG_ADDR_BUS-1:0] wb_waddr,
    input  logic [REG_BUS-1:0]      wb_wdata,
    output logic [REG_BUS-1:0]      rdata
);

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        rdata = '0;
        if (!rst && re && raddr != ZERO_REG_ADDR) begin
            if (wb_we && wb_waddr == raddr) begin
                rdata = wb_wdata;
            end else begin
                rdata = array_data;
            end
        end
    end
`else
    always_comb begin
        rdata = '0;
        if (!rst && re && raddr != ZERO_REG_ADDR) begin
            rdata = array_data;
        end
    end

    // Writeback register is not consulted without bypass.
    logic unused_bypass;
    assign unused_bypass = ^{wb_we, wb_waddr, wb_wdata};
`endif

endmodule

// File: rtl/wb_regfile.sv
// Writeback pipeline register, 32x32 architectural register file and retired-write counter.
// Define REGFILE_BYPASS_EN to forward the writeback register onto the read ports.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall_i,
    input  logic                    flush_i,
    wb_regfile_if.slave             ex,
    input  logic                    re1,
    input  logic [REG_ADDR_BUS-1:0] raddr1,
    output logic [REG_BUS-1:0]      rdata1,
    input  logic                    re2,
    input  logic [REG_ADDR_BUS-1:0] raddr2,
    output logic [REG_BUS-1:0]      rdata2,
    output logic [REG_ADDR_BUS-1:0] wb_waddr_o,
    output logic                    wb_we_o,
    output logic [REG_BUS-1:0]      wb_wdata_o,
    output logic [INSTRET_BUS-1:0]  instret_o
);

    wb_req_t            wb_q;
    logic [REG_BUS-1:0] regs [REG_NUM];
    logic               commit;
    logic               do_write;

    // A held register does not retire; flush overrides stall so the content still retires.
    assign commit   = !(stall_i && !flush_i);
    assign do_write = commit && wb_q.we && (wb_q.addr != ZERO_REG_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q      <= '0;
            instret_o <= '0;
            for (int i = 0; i < int'(REG_NUM); i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (do_write) begin
                regs[wb_q.addr] <= wb_q.data;
                instret_o       <= instret_o + INSTRET_BUS'(1);
            end
            if (flush_i) begin
                wb_q <= '0;
            end else if (!stall_i) begin
                wb_q <= ex.req;
            end
        end
    end

    assign wb_waddr_o = wb_q.addr;
    assign wb_we_o    = wb_q.we;
    assign wb_wdata_o = wb_q.data;

    wb_regfile_rd_port u_rd1 (
        .rst        (rst),
        .re         (re1),
        .raddr      (raddr1),
        .array_data (regs[raddr1]),
        .wb_we      (wb_q.we),
        .wb_waddr   (wb_q.addr),
        .wb_wdata   (wb_q.data),
        .rdata      (rdata1)
    );

    wb_regfile_rd_port u_rd2 (
        .rst        (rst),
        .re         (re2),
        .raddr      (raddr2),
        .array_data (regs[raddr2]),
        .wb_we      (wb_q.we),
        .wb_waddr   (wb_q.addr),
        .wb_wdata   (wb_q.data),
        .rdata      (rdata2)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against an array-based reference model.
`timescale 1ns/1ps
module tb_wb_regfile;
    import wb_regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        re1;
    logic        re2;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [4:0]  wb_waddr;
    logic        wb_we;
    logic [31:0] wb_wdata;
    logic [63:0] instret;

    wb_regfile_if bus ();

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall),
        .flush_i    (flush),
        .ex         (bus),
        .re1        (re1),
        .raddr1     (raddr1),
        .rdata1     (rdata1),
        .re2        (re2),
        .raddr2     (raddr2),
        .rdata2     (rdata2),
        .wb_waddr_o (wb_waddr),
        .wb_we_o    (wb_we),
        .wb_wdata_o (wb_wdata),
        .instret_o  (instret)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: architectural array, pending writeback slot, retire count.
    logic [31:0] m_arr [32];
    logic [4:0]  m_wa;
    logic        m_we;
    logic [31:0] m_wd;
    logic [63:0] m_ir;
    bit          model_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
        if (rst || !re || a == 5'd0) return 32'd0;
        if (BYP && m_we && m_wa == a) return m_wd;
        return m_arr[a];
    endfunction

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 32; i++) m_arr[i] = 32'd0;
            m_wa = 5'd0; m_we = 1'b0; m_wd = 32'd0; m_ir = 64'd0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (!(stall && !flush) && m_we && m_wa != 5'd0) begin
                m_arr[m_wa] = m_wd;
                m_ir = m_ir + 64'd1;
            end
            if (flush) begin
                m_wa = 5'd0; m_we = 1'b0; m_wd = 32'd0;
            end else if (!stall) begin
                m_wa = bus.req.addr; m_we = bus.req.we; m_wd = bus.req.data;
            end
        end
    endtask

    task automatic compare();
        chk("rdata1", rdata1, exp_rd(re1, raddr1));
        chk("rdata2", rdata2, exp_rd(re2, raddr2));
        chk("wb_waddr", wb_waddr, m_wa);
        chk("wb_we", wb_we, m_we);
        chk("wb_wdata", wb_wdata, m_wd);
        chk("instret", instret, m_ir);
    endtask

    // Inputs are set just after a falling edge; outputs are compared 1ns later.
    task automatic cycle();
        #1;
        if (model_valid) compare();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic req(input logic we, input logic [4:0] a, input logic [31:0] d);
        bus.req.we   = we;
        bus.req.addr = a;
        bus.req.data = d;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        re1 = 1'b0; re2 = 1'b0; raddr1 = 5'd0; raddr2 = 5'd0;
        req(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        cycle();
        rst = 1'b0;

        // Every register reads 0 on both ports after reset.
        re1 = 1'b1; re2 = 1'b1;
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a); raddr2 = 5'(31 - a);
            #1;
            chk("reset_rd1", rdata1, 64'd0);
            chk("reset_rd2", rdata2, 64'd0);
            cycle();
        end
        chk("reset_instret", instret, 64'd0);
        chk("reset_wb_we", wb_we, 64'd0);

        // Basic write to x5.
        req(1'b1, 5'd5, 32'hDEADBEEF); raddr1 = 5'd5;
        cycle();
        req(1'b0, 5'd0, 32'd0);
        #1;
        chk("basic_c1", rdata1, BYP ? 64'hDEADBEEF : 64'd0);
        chk("basic_c1_we", wb_we, 64'd1);
        cycle();
        #1;
        chk("basic_c2", rdata1, 64'hDEADBEEF);
        chk("basic_instret", instret, 64'd1);

        // Write to x0 occupies the slot but never lands or counts.
        req(1'b1, 5'd0, 32'h1234); raddr1 = 5'd0;
        cycle();
        req(1'b0, 5'd0, 32'd0);
        #1;
        chk("x0_wb_we", wb_we, 64'd1);
        chk("x0_rd", rdata1, 64'd0);
        cycle();
        #1;
        chk("x0_instret", instret, 64'd1);
        chk("x0_rd_after", rdata1, 64'd0);

        // Stall holds x3/7 while x4/9 waits at the input.
        req(1'b1, 5'd3, 32'd7); raddr1 = 5'd3; raddr2 = 5'd4;
        cycle();
        req(1'b1, 5'd4, 32'd9); stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_waddr", wb_waddr, 64'd3);
            chk("stall_wdata", wb_wdata, 64'd7);
            chk("stall_instret", instret, 64'd1);
            cycle();
        end
        stall = 1'b0; req(1'b0, 5'd0, 32'd0);
        #1;
        chk("stall_pre_rd", rdata1, BYP ? 64'd7 : 64'd0);
        cycle();
        #1;
        chk("stall_x3", rdata1, 64'd7);
        chk("stall_x4", rdata2, 64'd0);
        chk("stall_instret_after", instret, 64'd2);

        // Flush loads a bubble.
        req(1'b1, 5'd6, 32'd1); flush = 1'b1; raddr1 = 5'd6;
        cycle();
        flush = 1'b0; req(1'b0, 5'd0, 32'd0);
        #1;
        chk("flush_we", wb_we, 64'd0);
        chk("flush_waddr", wb_waddr, 64'd0);
        chk("flush_wdata", wb_wdata, 64'd0);
        cycle();
        #1;
        chk("flush_x6", rdata1, 64'd0);
        chk("flush_instret", instret, 64'd2);

        // Flush with stall still retires the pending x2=5.
        req(1'b1, 5'd2, 32'd5); raddr1 = 5'd2;
        cycle();
        req(1'b1, 5'd9, 32'd3); flush = 1'b1; stall = 1'b1;
        cycle();
        flush = 1'b0; stall = 1'b0; req(1'b0, 5'd0, 32'd0);
        #1;
        chk("fs_we", wb_we, 64'd0);
        chk("fs_x2", rdata1, 64'd5);
        chk("fs_instret", instret, 64'd3);
        cycle();

        // Reset discards a pending write.
        req(1'b1, 5'd7, 32'hAA); raddr1 = 5'd7;
        cycle();
        rst = 1'b1; req(1'b0, 5'd0, 32'd0);
        #1;
        chk("rst_rd_during", rdata1, 64'd0);
        cycle();
        #1;
        chk("rst_instret", instret, 64'd0);
        chk("rst_wb_we", wb_we, 64'd0);
        rst = 1'b0;
        cycle();
        #1;
        chk("rst_x7", rdata1, 64'd0);
        chk("rst_instret_after", instret, 64'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            rst   = ($urandom_range(0, 99) == 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            req($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
            re1 = ($urandom_range(0, 7) != 0);
            re2 = ($urandom_range(0, 7) != 0);
            raddr1 = 5'($urandom_range(0, 31));
            raddr2 = (n % 3 == 0) ? bus.req.addr : 5'($urandom_range(0, 31));
            cycle();
        end
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        req(1'b0, 5'd0, 32'd0);
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
